// File: rtl/wr_arbiter_if.sv
// Worker-result bus between NUM_PORTS requesters, the merge arbiter and the dispatcher.
// The "slave" modport is the arbiter's view; the "master" modport is the surrounding fabric.
interface wr_arbiter_if #(
  parameter int unsigned NUM_PORTS           = 4,
  parameter int unsigned WORKER_RESULT_WIDTH = 67
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]                     RECEIVE_WR_VALID;
  logic [NUM_PORTS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA;
  logic [NUM_PORTS-1:0]                     RECEIVE_WR_READY;
  logic                                     SEND_WR_VALID;
  logic [WORKER_RESULT_WIDTH-1:0]           SEND_WR_DATA;
  logic                                     SEND_WR_READY;
  logic [PW-1:0]                            SEND_WR_PORT;

  modport slave (
    input  RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_WR_READY,
    output RECEIVE_WR_READY, SEND_WR_VALID, SEND_WR_DATA, SEND_WR_PORT
  );

  modport master (
    output RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_WR_READY,
    input  RECEIVE_WR_READY, SEND_WR_VALID, SEND_WR_DATA, SEND_WR_PORT
  );
endinterface

// File: rtl/wr_arbiter.sv
// Round-robin merge of per-worker results into one registered output slot.
// Pass-through only: result contents (including NOP/END options) are never inspected.
module wr_arbiter #(
  parameter int unsigned NUM_PORTS           = 4,
  parameter int unsigned WORKER_RESULT_WIDTH = 67
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HALT,
  wr_arbiter_if.slave bus
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned W  = WORKER_RESULT_WIDTH;

  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_port;
  logic                 r_valid;
  logic [W-1:0]         r_data;

  logic                 w_slot_free;
  logic                 w_found;
  logic                 w_accept;
  logic [PW-1:0]        w_grant;
  logic [PW-1:0]        w_idx;
  logic [NUM_PORTS-1:0] w_ready;
  logic [W-1:0]         w_sel_data;

  // First valid port at or above r_ptr; PW-bit addition wraps because NUM_PORTS is a power of two.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      w_idx = r_ptr + PW'(k);
      if (!w_found && bus.RECEIVE_WR_VALID[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_slot_free = !r_valid || bus.SEND_WR_READY;
  assign w_accept    = w_slot_free && !HALT && !RST && w_found;
  assign w_sel_data  = bus.RECEIVE_WR_DATA[32'(w_grant)*W +: W];

  always_comb begin
    w_ready = '0;
    if (w_accept) w_ready[w_grant] = 1'b1;
  end

  // Output slot: load on accept (overrides a same-cycle drain), clear on drain alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr   <= '0;
      r_port  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_grant + PW'(1);
      r_port  <= w_grant;
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
    end else if (bus.SEND_WR_READY) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.RECEIVE_WR_READY = w_ready;
  assign bus.SEND_WR_VALID    = r_valid;
  assign bus.SEND_WR_DATA     = r_data;
  assign bus.SEND_WR_PORT     = r_port;
endmodule

// File: tb/tb_wr_arbiter.sv
// Directed bench for wr_arbiter: reset, round-robin order, backpressure, HALT,
// single requester, wrap-around, dropped VALID and reset mid-stream.
module tb_wr_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned W  = 67;

  logic clk;
  logic rst;
  logic halt;
  int   n_vec;
  int   n_miss;
  int   exp_port;
  logic [W-1:0] pd [NP];

  wr_arbiter_if #(.NUM_PORTS(NP), .WORKER_RESULT_WIDTH(W)) bus ();

  wr_arbiter #(.NUM_PORTS(NP), .WORKER_RESULT_WIDTH(W)) dut (
    .CLK  (clk),
    .RST  (rst),
    .HALT (halt),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < int'(NP); i++) bus.RECEIVE_WR_DATA[i*W +: W] = pd[i];
  endtask

  task automatic chk_out(input string tag, input int port);
    chk({tag, "_valid"}, 128'(bus.SEND_WR_VALID), 128'(1'b1));
    chk({tag, "_port"},  128'(bus.SEND_WR_PORT),  128'(port));
    chk({tag, "_data"},  128'(bus.SEND_WR_DATA),  128'(pd[port]));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < int'(NP); i++)
      pd[i] = {3'(i*2 + 1), 16'hA000 + 16'(i), 16'hC0C0 ^ 16'(i), 32'hDEAD_0000 + 32'(i)};
    rst  = 1'b1;
    halt = 1'b0;
    bus.SEND_WR_READY    = 1'b0;
    bus.RECEIVE_WR_VALID = 4'b1111;
    drive_data();

    // Reset with every port requesting
    cyc(); #1;
    chk("rst_ready", 128'(bus.RECEIVE_WR_READY), 128'(4'b0000));
    chk("rst_valid", 128'(bus.SEND_WR_VALID),    128'(1'b0));
    chk("rst_data",  128'(bus.SEND_WR_DATA),     128'(0));
    chk("rst_port",  128'(bus.SEND_WR_PORT),     128'(0));
    cyc();
    rst = 1'b0;
    #1;
    chk("first_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b0001));
    cyc(); #1;
    chk_out("first_accept", 0);
    chk("bp_ready0", 128'(bus.RECEIVE_WR_READY), 128'(4'b0000));

    // Backpressure: slot holds for 5 cycles
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk_out("bp_hold", 0);
      chk("bp_ready", 128'(bus.RECEIVE_WR_READY), 128'(4'b0000));
    end
    bus.SEND_WR_READY = 1'b1;
    #1;
    chk("bp_release_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b0010));

    // Full round robin, one per cycle
    exp_port = 1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 128'(bus.RECEIVE_WR_READY), 128'(4'b0001 << exp_port));
      cyc(); #1;
      chk_out("rr_out", exp_port);
      exp_port = (exp_port + 1) % int'(NP);
    end

    // HALT: held result drains, nothing new accepted, resume from PTR=3
    halt = 1'b1;
    #1;
    chk("halt_ready", 128'(bus.RECEIVE_WR_READY), 128'(4'b0000));
    cyc(); #1;
    chk("halt_drained", 128'(bus.SEND_WR_VALID), 128'(1'b0));
    cyc(); #1;
    chk("halt_idle_valid", 128'(bus.SEND_WR_VALID),    128'(1'b0));
    chk("halt_idle_ready", 128'(bus.RECEIVE_WR_READY), 128'(4'b0000));
    halt = 1'b0;
    #1;
    chk("resume_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b1000));
    cyc(); #1;
    chk_out("resume_out", 3);

    // Single requester on port 2
    pd[2] = {3'd1, 16'h1111, 16'h2222, 32'h3333_4444};
    drive_data();
    bus.RECEIVE_WR_VALID = 4'b0100;
    #1;
    chk("single_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b0100));
    cyc(); #1;
    chk_out("single_out", 2);
    bus.RECEIVE_WR_VALID = 4'b0000;
    cyc(); #1;
    chk("single_drained", 128'(bus.SEND_WR_VALID), 128'(1'b0));

    // Wrap-around from PTR=3 to port 0
    bus.RECEIVE_WR_VALID = 4'b0011;
    #1;
    chk("wrap_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b0001));
    cyc();
    bus.SEND_WR_READY = 1'b0;
    #1;
    chk_out("wrap_out", 0);

    // Port 1 drops VALID while blocked; search from PTR=1 lands on port 0
    bus.RECEIVE_WR_VALID = 4'b0001;
    cyc();
    bus.SEND_WR_READY = 1'b1;
    #1;
    chk("drop_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b0001));
    cyc();
    bus.SEND_WR_READY    = 1'b0;
    bus.RECEIVE_WR_VALID = 4'b1111;
    #1;
    chk_out("drop_out", 0);

    // Reset mid-stream while a result is held (PTR=1)
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst_valid", 128'(bus.SEND_WR_VALID),    128'(1'b0));
    chk("mrst_data",  128'(bus.SEND_WR_DATA),     128'(0));
    chk("mrst_port",  128'(bus.SEND_WR_PORT),     128'(0));
    chk("mrst_ready", 128'(bus.RECEIVE_WR_READY), 128'(4'b0000));
    cyc();
    rst = 1'b0;
    bus.SEND_WR_READY = 1'b1;
    #1;
    chk("mrst_grant", 128'(bus.RECEIVE_WR_READY), 128'(4'b0001));
    cyc(); #1;
    chk_out("mrst_out", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
